// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the EX-stage string-operation unit.
package cv32e40p_pkg;

    localparam int unsigned STR_OP_WIDTH = 2;

    typedef enum logic [STR_OP_WIDTH-1:0] {
        STR_NONE = 2'd0,
        STR_LEN  = 2'd1,
        STR_NLEN = 2'd2
    } str_opcode_e;

    // Limit used by STRLEN, so the NUL test always decides first.
    localparam logic [31:0] STR_NLEN_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/cv32e40p_str_byte_scan.sv
// Scans one little-endian load word for a NUL byte or the length limit,
// starting at a byte lane offset, and returns the updated length count.
module cv32e40p_str_byte_scan (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [31:0] count,
    input  logic [31:0] limit,
    output logic        found,
    output logic [31:0] count_new
);

    always_comb begin
        found     = 1'b0;
        count_new = count;
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if (!found && (lane >= 32'(offset))) begin
                // The limit check wins over a NUL in the same byte position.
                if (count_new == limit) begin
                    found = 1'b1;
                end else if (rdata[8*lane +: 8] == 8'h00) begin
                    found = 1'b1;
                end else begin
                    count_new = count_new + 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cv32e40p_str_ctrl.sv
// String-op sequencer: issues one-outstanding word loads, counts bytes up to
// a NUL or limit, and stalls EX until the length result is ready.
module cv32e40p_str_ctrl #(
    parameter int STR_OP_WIDTH = cv32e40p_pkg::STR_OP_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_a_i,
    input  logic [31:0]             operand_b_i,
    input  logic                    flush_i,
    input  logic                    ex_ready_i,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [31:0]             data_addr_o,
    input  logic                    data_rvalid_i,
    input  logic [31:0]             data_rdata_i,
    input  logic                    data_err_i,
    output logic [31:0]             result_o,
    output logic                    ready_o,
    output logic                    err_o
);

    import cv32e40p_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } state_e;

    state_e      state;
    logic [1:0]  offset_q;
    logic [31:0] limit_q;
    logic [31:0] count_q;
    logic        flush_q;

    logic        is_len;
    logic        is_nlen;
    logic        scan_found;
    logic [31:0] scan_count;

    assign is_len  = (operator_i == STR_OP_WIDTH'(STR_LEN));
    assign is_nlen = (operator_i == STR_OP_WIDTH'(STR_NLEN));

    cv32e40p_str_byte_scan u_byte_scan (
        .rdata     (data_rdata_i),
        .offset    (offset_q),
        .count     (count_q),
        .limit     (limit_q),
        .found     (scan_found),
        .count_new (scan_count)
    );

    // data_addr_o doubles as the latched word address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_req_o  <= 1'b0;
            data_addr_o <= '0;
            result_o    <= '0;
            ready_o     <= 1'b1;
            err_o       <= 1'b0;
            offset_q    <= '0;
            limit_q     <= '0;
            count_q     <= '0;
            flush_q     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable_i && !flush_i && (is_len || is_nlen)) begin
                        data_addr_o <= {operand_a_i[31:2], 2'b00};
                        offset_q    <= operand_a_i[1:0];
                        limit_q     <= is_nlen ? operand_b_i : STR_NLEN_MAX;
                        count_q     <= '0;
                        result_o    <= '0;
                        if (is_nlen && (operand_b_i == '0)) begin
                            state   <= DONE;
                            ready_o <= 1'b1;
                        end else begin
                            state      <= REQ;
                            data_req_o <= 1'b1;
                            ready_o    <= 1'b0;
                        end
                    end else if (enable_i) begin
                        result_o <= '0;
                    end
                end

                REQ: begin
                    // A flush cannot retract an issued request; remember it until grant.
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        flush_q    <= 1'b0;
                        state      <= (flush_i || flush_q) ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        flush_q <= 1'b1;
                    end
                end

                WAIT: begin
                    if (flush_i) begin
                        if (data_rvalid_i) begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (data_rvalid_i) begin
                        if (data_err_i) begin
                            err_o    <= 1'b1;
                            result_o <= '0;
                            state    <= DONE;
                            ready_o  <= 1'b1;
                        end else if (scan_found) begin
                            count_q  <= scan_count;
                            result_o <= scan_count;
                            state    <= DONE;
                            ready_o  <= 1'b1;
                        end else begin
                            count_q     <= scan_count;
                            data_addr_o <= data_addr_o + 32'd4;
                            offset_q    <= '0;
                            data_req_o  <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end

                DONE: begin
                    if (flush_i || ex_ready_i) begin
                        result_o <= '0;
                        state    <= IDLE;
                    end
                end

                DRAIN: begin
                    if (data_rvalid_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    data_req_o <= 1'b0;
                    ready_o    <= 1'b1;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_str_ctrl.sv
// Self-checking bench for cv32e40p_str_ctrl: directed plan cases plus random
// string ops against a byte-stream reference model and an OBI responder.
module tb_cv32e40p_str_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [1:0]  operator_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        flush_i;
    logic        ex_ready_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] words [4];

    cv32e40p_str_ctrl #(.STR_OP_WIDTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .operator_i    (operator_i),
        .operand_a_i   (operand_a_i),
        .operand_b_i   (operand_b_i),
        .flush_i       (flush_i),
        .ex_ready_i    (ex_ready_i),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i),
        .result_o      (result_o),
        .ready_o       (ready_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Stream byte i is memory byte (offset + i); the length is the first NUL
    // index clipped to the limit, and loads cover every word up to the stop byte.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int err_at, output logic [31:0] res, output int loads,
                                  output int err);
        logic [31:0] lim;
        int          off;
        int          n;
        int          idx;
        int          p;
        logic [7:0]  by;
        lim   = (op == 2'd2) ? b : 32'hFFFF_FFFF;
        off   = int'(a[1:0]);
        res   = '0;
        loads = 0;
        err   = 0;
        if (lim == 32'd0) return;
        n = 0;
        while (n < 16 - off) begin
            idx = off + n;
            by  = 8'(words[idx / 4] >> (8 * (idx % 4)));
            if (by == 8'h00) break;
            n++;
        end
        p     = (lim < 32'(n)) ? int'(lim) : n;
        res   = 32'(p);
        loads = (off + p) / 4 + 1;
        if (err_at >= 0 && err_at < loads) begin
            res   = '0;
            loads = err_at + 1;
            err   = 1;
        end
    endfunction

    task automatic clear_bus();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        flush_i       = 1'b0;
        enable_i      = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int gd, input int rd, input int err_at, input int flush_at,
                          input bit hold_en, input bit done_flush);
        logic [31:0] exp_res;
        logic [31:0] base;
        int exp_loads, exp_err;
        int nload, low, errs, gcnt, rcnt, allowed;
        bit done, flushed, gnt_now;
        model(op, a, b, err_at, exp_res, exp_loads, exp_err);
        base = {a[31:2], 2'b00};
        enable_i    = 1'b1;
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        @(negedge clk);
        if (!hold_en) enable_i = 1'b0;
        nload = 0; low = 0; errs = 0; gcnt = 0; rcnt = -1; allowed = 0;
        done = 0; flushed = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (err_o) errs++;
            if (ready_o) begin
                done = 1;
            end else begin
                low++;
                data_gnt_i    = 1'b0;
                data_rvalid_i = 1'b0;
                data_err_i    = 1'b0;
                data_rdata_i  = $urandom;
                flush_i       = 1'b0;
                gnt_now       = 0;
                if (rcnt >= 0) begin
                    check_eq("req_low_in_wait", data_req_o, 0);
                    if (rcnt == 0) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = words[(nload - 1) % 4];
                        data_err_i    = (nload - 1 == err_at);
                    end
                    rcnt--;
                end else if (data_req_o) begin
                    check_eq("addr", data_addr_o, base + 32'(4 * nload));
                    if (gcnt == gd) begin
                        gnt_now    = 1;
                        data_gnt_i = 1'b1;
                        gcnt       = 0;
                        rcnt       = rd;
                        nload++;
                        if (flushed) begin
                            allowed--;
                            check_eq("req_after_flush", 32'(allowed < 0), 0);
                        end
                    end else begin
                        gcnt++;
                    end
                end
                if (cyc == flush_at) begin
                    flush_i = 1'b1;
                    flushed = 1;
                    allowed = (data_req_o && !gnt_now) ? 1 : 0;
                end
                if (hold_en) begin
                    enable_i    = 1'b1;
                    operator_i  = 2'($urandom);
                    operand_a_i = $urandom;
                end
                @(negedge clk);
            end
        end
        clear_bus();
        check_eq("timeout", 32'(done), 1);
        if (flushed) begin
            check_eq("flush_no_err", errs, 0);
            check_eq("flush_drained", 32'(rcnt < 0 && allowed <= 0), 1);
            check_eq("flush_req_idle", data_req_o, 0);
        end else begin
            check_eq("result", result_o, exp_res);
            check_eq("loads", nload, exp_loads);
            check_eq("err_pulses", errs, exp_err);
            check_eq("ready_low_cycles", low, exp_loads * (gd + rd + 2));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_eq("result_hold", result_o, exp_res);
                check_eq("err_single", err_o, 0);
                check_eq("ready_done", ready_o, 1);
            end
            if (done_flush) flush_i = 1'b1;
            else ex_ready_i = 1'b1;
            @(negedge clk);
            flush_i    = 1'b0;
            ex_ready_i = 1'b0;
            check_eq("err_after", err_o, 0);
            check_eq("ready_idle", ready_o, 1);
            check_eq("req_idle", data_req_o, 0);
        end
    endtask

    task automatic run_nop(input logic [1:0] op);
        enable_i    = 1'b1;
        operator_i  = op;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        @(negedge clk);
        enable_i = 1'b0;
        check_eq("nop_ready", ready_o, 1);
        check_eq("nop_req", data_req_o, 0);
        check_eq("nop_result", result_o, 0);
        @(negedge clk);
        check_eq("nop_req2", data_req_o, 0);
    endtask

    task automatic gen_words(input logic [1:0] off);
        int n;
        logic [7:0] bv;
        n = $urandom_range(0, 15 - int'(off));
        for (int k = 0; k < 16; k++) begin
            bv = 8'($urandom_range(1, 255));
            if (k - int'(off) == n) bv = 8'h00;
            else if (k < int'(off) && $urandom_range(0, 1) == 1) bv = 8'h00;
            words[k / 4][8 * (k % 4) +: 8] = bv;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        operator_i    = '0;
        operand_a_i   = '0;
        operand_b_i   = '0;
        ex_ready_i    = 1'b0;
        data_rdata_i  = '0;
        clear_bus();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req", data_req_o, 0);
        check_eq("rst_addr", data_addr_o, 0);
        check_eq("rst_result", result_o, 0);
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_err", err_o, 0);

        // "abc\0", grant one cycle late: 3 stall cycles
        words[0] = 32'h0063_6261;
        run_op(2'd1, 32'h0000_1000, 32'd0, 1, 0, -1, -1, 0, 0);
        // minimum latency
        run_op(2'd1, 32'h0000_1000, 32'd0, 0, 0, -1, -1, 0, 0);
        // misaligned start, masked lanes hold zeros
        words[0] = 32'h4142_0000;
        words[1] = 32'h0044_4443;
        run_op(2'd1, 32'h0000_2002, 32'd0, 0, 0, -1, -1, 0, 0);
        // limit reached inside second word
        for (int i = 0; i < 4; i++) words[i] = 32'h6161_6161;
        run_op(2'd2, 32'h0000_3000, 32'd5, 0, 0, -1, -1, 0, 0);
        // limit exactly at word boundary
        run_op(2'd2, 32'h0000_3000, 32'd4, 0, 1, -1, -1, 1, 0);
        // limit zero: no bus access
        run_op(2'd2, 32'h0000_3000, 32'd0, 0, 0, -1, -1, 0, 0);
        // limit and NUL at the same byte
        words[0] = 32'h0061_6161;
        run_op(2'd2, 32'h0000_4000, 32'd3, 0, 0, -1, -1, 0, 0);
        // delayed grant then bus error
        run_op(2'd1, 32'h0000_5000, 32'd0, 3, 0, 0, -1, 0, 0);
        // address wrap
        words[0] = 32'h4141_0000;
        words[1] = 32'h0041_4141;
        run_op(2'd1, 32'hFFFF_FFFE, 32'd0, 0, 0, -1, -1, 0, 1);
        // flush in WAIT, response two cycles later, with error ignored
        for (int i = 0; i < 4; i++) words[i] = 32'h6262_6262;
        run_op(2'd1, 32'h0000_6000, 32'd0, 0, 2, 0, 1, 0, 0);
        // flush in WAIT with rvalid in the same cycle
        run_op(2'd1, 32'h0000_6000, 32'd0, 0, 1, -1, 2, 0, 0);
        // flush in REQ before grant, and with grant in the same cycle
        run_op(2'd1, 32'h0000_7000, 32'd0, 3, 1, 0, 1, 0, 0);
        run_op(2'd1, 32'h0000_7000, 32'd0, 2, 0, -1, 2, 0, 0);
        run_nop(2'd0);
        run_nop(2'd3);

        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r == 0) begin
                run_nop(($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0);
            end else begin
                gen_words(a[1:0]);
                run_op((r < 5) ? 2'd1 : 2'd2, a,
                       (r < 5) ? $urandom : 32'($urandom_range(0, 18)),
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
                       ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // asynchronous reset in the middle of a request
        for (int i = 0; i < 4; i++) words[i] = 32'h6363_6363;
        enable_i    = 1'b1;
        operator_i  = 2'd1;
        operand_a_i = 32'h0000_8004;
        @(negedge clk);
        enable_i = 1'b0;
        check_eq("pre_rst_req", data_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_req", data_req_o, 0);
        check_eq("async_rst_addr", data_addr_o, 0);
        check_eq("async_rst_ready", ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req", data_req_o, 0);
        check_eq("post_rst_ready", ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
